// File: rtl/div_nr_sched.sv
// Two-requester round-robin scheduler around one shared non-restoring divider.
// Optional overflow shortcut: define DIV_NR_SCHED_OVF_CHK_EN to send operands
// with a[A_W-1:B_W] >= b straight to DONE with an error response.
module div_nr_sched #(
  parameter int unsigned A_W     = 8,
  parameter int unsigned B_W     = 4,
  parameter int unsigned RR_INIT = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [A_W-1:0] req0_a,
  input  logic [B_W-1:0] req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [A_W-1:0] req1_a,
  input  logic [B_W-1:0] req1_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [A_W-1:0] rsp_rslt,
  output logic           rsp_err,
  output logic           busy
);

  localparam int unsigned CNT_W = $clog2(B_W + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             rr_q, rr_d;
  logic             id_q, id_d;
  logic [B_W-1:0]   b_q, b_d;
  logic [B_W:0]     p_q, p_d;
  logic [B_W-1:0]   q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [A_W-1:0]   rslt_q, rslt_d;
  logic             err_q, err_d;

  logic             idle;
  logic             gnt0, gnt1;
  logic [A_W-1:0]   sel_a;
  logic [B_W-1:0]   sel_b;
  logic             div0, ovf;
  logic [B_W:0]     b_ext, p_sh, p_new, p_fix;
  logic [B_W-1:0]   q_new;

  // Grant: sole valid requester, or the rr-preferred one when both are valid
  always_comb begin
    idle  = (state_q == S_IDLE);
    gnt0  = rst_n & idle & req0_valid & (~req1_valid | ~rr_q);
    gnt1  = rst_n & idle & req1_valid & (~req0_valid | rr_q);
    sel_a = gnt1 ? req1_a : req0_a;
    sel_b = gnt1 ? req1_b : req0_b;
    div0  = (sel_b == '0);
`ifdef DIV_NR_SCHED_OVF_CHK_EN
    ovf   = ~div0 & (B_W'(sel_a[A_W-1:B_W]) >= sel_b);
`else
    ovf   = 1'b0;
`endif
  end

  // One non-restoring step and the final remainder correction
  always_comb begin
    b_ext = {1'b0, b_q};
    p_sh  = {p_q[B_W-1:0], q_q[B_W-1]};
    p_new = p_q[B_W] ? (p_sh + b_ext) : (p_sh - b_ext);
    q_new = {q_q[B_W-2:0], ~p_new[B_W]};
    p_fix = p_q[B_W] ? (p_q + b_ext) : p_q;
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    b_d     = b_q;
    p_d     = p_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    rslt_d  = rslt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (gnt0 | gnt1) begin
          id_d  = gnt1;
          rr_d  = gnt0;
          b_d   = sel_b;
          p_d   = {1'b0, B_W'(sel_a[A_W-1:B_W])};
          q_d   = sel_a[B_W-1:0];
          cnt_d = CNT_W'(B_W);
          if (div0 | ovf) begin
            rslt_d  = '1;
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_ITER;
          end
        end
      end
      S_ITER: begin
        p_d   = p_new;
        q_d   = q_new;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        rslt_d  = A_W'({p_fix[B_W-1:0], q_q});
        err_d   = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rr_q    <= 1'(RR_INIT);
      id_q    <= 1'b0;
      b_q     <= '0;
      p_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      rslt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      b_q     <= b_d;
      p_q     <= p_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      rslt_q  <= rslt_d;
      err_q   <= err_d;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp_valid  = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign rsp_id     = id_q;
  assign rsp_rslt   = rslt_q;
  assign rsp_err    = err_q;

endmodule
